// File: rtl/ball_court.sv
// ball_court: 1-D ball/rally engine for the LED court; define SPEEDUP_EN to shorten the step period on each hit
module ball_court #(
  parameter int COURT_LEN = 16,
  parameter int POS_W     = 5,
  parameter int HIT_WIN   = 1,
  parameter int STEP_DIV  = 4,
  parameter int HIT_W     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 left_hit,
  input  logic                 right_hit,
  input  logic [1:0]           serve,
  output logic [1:0]           direction,
  output logic [COURT_LEN-1:0] light,
  output logic [HIT_W-1:0]     hitnum,
  output logic                 miss_lo,
  output logic                 miss_hi
);
  localparam int DW = $clog2(STEP_DIV + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV);
  localparam logic [POS_W-1:0] P_ONE = POS_W'(1);
  localparam logic [POS_W-1:0] P_LEN = POS_W'(COURT_LEN);
  localparam logic [POS_W-1:0] P_WIN_HI = POS_W'(COURT_LEN - HIT_WIN + 1);
  localparam logic [POS_W-1:0] P_WIN_LO = POS_W'(HIT_WIN);
  localparam logic [HIT_W-1:0] H_MAX = '1;

  typedef enum logic [1:0] {IDLE, UP, DOWN, DEAD} state_t;

  state_t               r_state;
  logic [POS_W-1:0]     r_pos;
  logic [DW-1:0]        r_div;
  logic [DW-1:0]        w_period;
  logic [DW-1:0]        w_reload;
  logic                 w_tick;
  logic                 w_serve;
  logic                 w_launch;
  logic                 w_hit_up;
  logic                 w_hit_dn;
  logic                 w_hit;
  logic                 w_step_up;
  logic                 w_step_dn;
  logic                 w_miss_hi;
  logic                 w_miss_lo;
  logic [COURT_LEN-1:0] w_light;

  // hit windows, step ticks, misses and the one-hot LED image of the current position
  always_comb begin
    w_tick    = r_div == '0;
    w_serve   = serve == 2'b01 || serve == 2'b10;
    w_launch  = r_state == IDLE && (left_hit || right_hit);
    w_hit_up  = r_state == UP && right_hit && r_pos >= P_WIN_HI;
    w_hit_dn  = r_state == DOWN && left_hit && r_pos <= P_WIN_LO;
    w_hit     = w_hit_up || w_hit_dn;
    w_step_up = r_state == UP && w_tick && !w_hit_up;
    w_step_dn = r_state == DOWN && w_tick && !w_hit_dn;
    w_miss_hi = w_step_up && r_pos == P_LEN;
    w_miss_lo = w_step_dn && r_pos == P_ONE;
    w_reload  = w_period - DW'(1);
    w_light   = '0;
    for (int i = 0; i < COURT_LEN; i++) w_light[i] = r_pos == POS_W'(i + 1);
  end

`ifdef SPEEDUP_EN
  logic [DW-1:0] r_period;

  assign w_period = w_serve ? DIV_MAX : (w_hit && r_period > DW'(1)) ? r_period - DW'(1) : r_period;

  // active step period: shrinks by one per successful return, restored by serve
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_period <= DIV_MAX;
    else r_period <= w_period;
  end
`else
  assign w_period = DIV_MAX;
`endif

  // rally state machine with registered outputs; serve overrides hits, ticks and misses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pos     <= P_ONE;
      r_div     <= DIV_MAX - DW'(1);
      direction <= 2'b00;
      light     <= COURT_LEN'(1);
      hitnum    <= '0;
      miss_lo   <= 1'b0;
      miss_hi   <= 1'b0;
    end else begin
      light   <= w_light;
      r_div   <= (r_state == IDLE || r_state == DEAD || w_serve || w_launch || w_hit || w_tick) ? w_reload : r_div - DW'(1);
      miss_hi <= !w_serve && w_miss_hi;
      miss_lo <= !w_serve && w_miss_lo;
      if (w_serve) begin
        r_state   <= IDLE;
        r_pos     <= serve[0] ? P_ONE : P_LEN;
        direction <= 2'b00;
        hitnum    <= '0;
      end else begin
        if (w_hit && hitnum != H_MAX) hitnum <= hitnum + HIT_W'(1);
        if (w_step_up) r_pos <= r_pos + P_ONE;
        else if (w_step_dn) r_pos <= r_pos - P_ONE;
        if (w_miss_hi || w_miss_lo) begin
          r_state   <= DEAD;
          direction <= 2'b00;
        end else if ((r_state == IDLE && left_hit) || w_hit_dn) begin
          r_state   <= UP;
          direction <= 2'b01;
        end else if ((r_state == IDLE && right_hit) || w_hit_up) begin
          r_state   <= DOWN;
          direction <= 2'b10;
        end
      end
    end
  end
endmodule
